jimmy_imem_arbiter: RTL and testbench

Shares one single-port, synchronous-read program ROM between two `jimmy` cores in the dual-core build. Each core raises a fetch request with its 8-bit instruction address. The arbiter serialises the requests round-robin, drives the ROM, and returns the instruction byte with a one-cycle grant pulse. The core wrapper uses that pulse as its clock enable. Per-core saturating wait counters expose fetch contention for profiling.

---
 rtl/jimmy_pkg.sv | 19 +
 rtl/jimmy_rr_pick.sv | 14 +
 rtl/jimmy_imem_arbiter.sv | 136 +++++++++++++
 tb/tb_jimmy_imem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jimmy_pkg.sv
// Shared encodings for the dual-core jimmy build: arbiter and core FSM states
// (both one-hot) and the core count.
package jimmy_pkg;

  localparam int NUM_CORES = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ISSUE  = 3'b010,
    RETURN = 3'b100
  } arb_state_e;

  typedef enum logic [2:0] {
    FETCH      = 3'b001,
    EXECUTE    = 3'b010,
    WRITE_BACK = 3'b100
  } core_state_e;

endpackage

// File: rtl/jimmy_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the core not granted last wins.
module jimmy_rr_pick
  import jimmy_pkg::*;
(
  input  logic [NUM_CORES-1:0] eligible,
  input  logic                 last,
  output logic                 valid,
  output logic                 sel
);

  assign valid = |eligible;
  assign sel   = (&eligible) ? ~last : eligible[1];

endmodule

// File: rtl/jimmy_imem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read program ROM between two jimmy
// cores, with per-core saturating fetch-wait counters for profiling.
module jimmy_imem_arbiter
  import jimmy_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 jimmy_clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req,
  input  logic [7:0]           addr_0,
  input  logic [7:0]           addr_1,
  input  logic                 clr_stats,
  output logic                 rom_en,
  output logic [7:0]           rom_addr,
  input  logic [7:0]           rom_data,
  output logic [7:0]           data_0,
  output logic [7:0]           data_1,
  output logic [NUM_CORES-1:0] grant,
  output logic                 busy,
  output logic [CNT_W-1:0]     wait_0,
  output logic [CNT_W-1:0]     wait_1
);

  arb_state_e           state_q;
  logic                 owner_q;
  logic                 last_q;
  logic                 rom_en_q;
  logic [7:0]           rom_addr_q;
  logic [7:0]           data_0_q;
  logic [7:0]           data_1_q;
  logic [NUM_CORES-1:0] grant_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     wait_0_q, wait_0_d;
  logic [CNT_W-1:0]     wait_1_q, wait_1_d;

  logic [NUM_CORES-1:0] eligible_s;
  logic                 valid_s;
  logic                 sel_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A core being granted this cycle still shows its old req/address, so mask it.
  assign eligible_s = req & ~grant_q;

  jimmy_rr_pick u_pick (
    .eligible (eligible_s),
    .last     (last_q),
    .valid    (valid_s),
    .sel      (sel_s)
  );

  always_ff @(posedge jimmy_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      rom_en_q   <= 1'b0;
      rom_addr_q <= 8'h00;
      data_0_q   <= 8'h00;
      data_1_q   <= 8'h00;
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          grant_q <= 2'b00;
          if (valid_s) begin
            owner_q    <= sel_s;
            rom_addr_q <= sel_s ? addr_1 : addr_0;
            rom_en_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          rom_en_q <= 1'b0;
          state_q  <= RETURN;
        end
        RETURN: begin
          if (owner_q) begin
            data_1_q <= rom_data;
            grant_q  <= 2'b10;
          end else begin
            data_0_q <= rom_data;
            grant_q  <= 2'b01;
          end
          last_q  <= owner_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          rom_en_q <= 1'b0;
          grant_q  <= 2'b00;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Clear beats increment; a core waits whenever it requests without a grant.
  always_comb begin
    wait_0_d = wait_0_q;
    wait_1_d = wait_1_q;
    if (clr_stats) begin
      wait_0_d = '0;
      wait_1_d = '0;
    end else begin
      if (req[0] && !grant_q[0]) wait_0_d = sat_inc(wait_0_q);
      if (req[1] && !grant_q[1]) wait_1_d = sat_inc(wait_1_q);
    end
  end

  always_ff @(posedge jimmy_clk or negedge reset) begin
    if (!reset) begin
      wait_0_q <= '0;
      wait_1_q <= '0;
    end else begin
      wait_0_q <= wait_0_d;
      wait_1_q <= wait_1_d;
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign data_0   = data_0_q;
  assign data_1   = data_1_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign wait_0   = wait_0_q;
  assign wait_1   = wait_1_q;

endmodule

// File: tb/tb_jimmy_imem_arbiter.sv
// Randomized self-checking bench for jimmy_imem_arbiter against a cycle-schedule
// reference model (fetch selected at T -> strobe at T+1 -> grant/data at T+3).
module tb_jimmy_imem_arbiter;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          jimmy_clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [7:0]    addr_0, addr_1;
  logic          clr_stats;
  logic          rom_en;
  logic [7:0]    rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    data_0, data_1;
  logic [1:0]    grant;
  logic          busy;
  logic [CW-1:0] wait_0, wait_1;

  logic [7:0] rom [256];

  jimmy_imem_arbiter #(.CNT_W(CW)) dut (
    .jimmy_clk (jimmy_clk),
    .reset     (reset),
    .req       (req),
    .addr_0    (addr_0),
    .addr_1    (addr_1),
    .clr_stats (clr_stats),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .data_0    (data_0),
    .data_1    (data_1),
    .grant     (grant),
    .busy      (busy),
    .wait_0    (wait_0),
    .wait_1    (wait_1)
  );

  always #5 jimmy_clk = ~jimmy_clk;

  // Synchronous-read program ROM
  always @(posedge jimmy_clk) if (rom_en) rom_data <= rom[rom_addr];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: expected visible outputs plus the schedule of the fetch in flight.
  int            issue_cyc, grant_cyc, next_arb;
  logic          m_owner, m_last;
  logic [7:0]    m_addr;
  logic          e_rom_en, e_busy;
  logic [7:0]    e_rom_addr;
  logic [7:0]    e_data [2];
  logic [1:0]    e_grant;
  logic [CW-1:0] e_wait [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check_val("rom_en",   32'(rom_en),   32'(e_rom_en));
    check_val("rom_addr", 32'(rom_addr), 32'(e_rom_addr));
    check_val("data_0",   32'(data_0),   32'(e_data[0]));
    check_val("data_1",   32'(data_1),   32'(e_data[1]));
    check_val("grant",    32'(grant),    32'(e_grant));
    check_val("busy",     32'(busy),     32'(e_busy));
    check_val("wait_0",   32'(wait_0),   32'(e_wait[0]));
    check_val("wait_1",   32'(wait_1),   32'(e_wait[1]));
  endtask

  task automatic model_reset();
    e_rom_en   = 1'b0;
    e_busy     = 1'b0;
    e_rom_addr = 8'h00;
    e_data[0]  = 8'h00;
    e_data[1]  = 8'h00;
    e_grant    = 2'b00;
    e_wait[0]  = '0;
    e_wait[1]  = '0;
    m_last     = 1'b1;
    m_owner    = 1'b0;
    m_addr     = 8'h00;
    issue_cyc  = -100;
    grant_cyc  = -100;
    next_arb   = cyc;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_update();
    logic [1:0] el;
    for (int n = 0; n < 2; n++) begin
      if (clr_stats) e_wait[n] = '0;
      else if (req[n] && !e_grant[n] && e_wait[n] != CMAX) e_wait[n] = e_wait[n] + 1'b1;
    end
    if (cyc >= next_arb) begin
      el = req & ~e_grant;
      if (el != 2'b00) begin
        if (el == 2'b11) m_owner = ~m_last;
        else             m_owner = (el == 2'b10);
        m_addr    = m_owner ? addr_1 : addr_0;
        issue_cyc = cyc + 1;
        grant_cyc = cyc + 3;
        next_arb  = cyc + 3;
      end
    end
    cyc++;
    e_rom_en = (cyc == issue_cyc);
    if (cyc == issue_cyc) e_rom_addr = m_addr;
    e_busy  = (cyc >= issue_cyc) && (cyc < grant_cyc);
    e_grant = 2'b00;
    if (cyc == grant_cyc) begin
      e_grant[m_owner] = 1'b1;
      e_data[m_owner]  = rom[m_addr];
      m_last           = m_owner;
    end
  endtask

  task automatic step(input logic [1:0] r, input logic [7:0] a0, input logic [7:0] a1, input logic c);
    @(negedge jimmy_clk);
    check_outputs();
    req       = r;
    addr_0    = a0;
    addr_1    = a1;
    clr_stats = c;
    model_update();
  endtask

  // Asynchronous reset at a falling edge: outputs must clear without a clock edge.
  task automatic do_reset(input int hold);
    @(negedge jimmy_clk);
    check_outputs();
    reset     = 1'b0;
    req       = 2'b00;
    clr_stats = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (hold) begin
      @(negedge jimmy_clk);
      check_outputs();
    end
    reset = 1'b1;
    model_update();
  endtask

  initial begin
    reset     = 1'b0;
    req       = 2'b00;
    addr_0    = 8'h00;
    addr_1    = 8'h00;
    clr_stats = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[5]  = 8'h83;
    rom[6]  = 8'h3C;
    rom[0]  = 8'h11;
    rom[16] = 8'hA5;
    model_reset();
    repeat (3) begin
      @(negedge jimmy_clk);
      check_outputs();
    end
    reset = 1'b1;
    model_update();

    // Single requester, then contention with strict alternation
    repeat (4) step(2'b01, 8'h05, 8'h00, 1'b0);
    repeat (3) step(2'b00, 8'h05, 8'h00, 1'b0);
    repeat (12) step(2'b11, 8'h00, 8'h10, 1'b0);
    repeat (3) step(2'b00, 8'h00, 8'h10, 1'b0);

    // Address changes during ISSUE and the request drops while in flight
    step(2'b01, 8'h05, 8'h00, 1'b0);
    step(2'b01, 8'h06, 8'h00, 1'b0);
    repeat (4) step(2'b00, 8'h06, 8'h00, 1'b0);

    // Reset during core 1's ISSUE; first grant afterwards must be core 0
    step(2'b10, 8'h00, 8'h20, 1'b0);
    do_reset(2);
    repeat (8) step(2'b11, 8'h00, 8'h10, 1'b0);

    // Drive both counters into saturation, then clear
    repeat (30) step(2'b11, 8'h05, 8'h10, 1'b0);
    step(2'b11, 8'h05, 8'h10, 1'b1);
    repeat (4) step(2'b11, 8'h05, 8'h10, 1'b0);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0)
        do_reset(int'($urandom_range(1, 3)));
      else
        step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), ($urandom_range(0, 19) == 0));
    end

    @(negedge jimmy_clk);
    check_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
